display_scan_ctrl: RTL and testbench

Parametrised successor to the 4-digit multiplexed display control: drives an N-digit common-anode seven-segment display by time-multiplexing digit strobes.
- Internal refresh prescaler; no external scan pulse.
- Frame-coherent snapshot of the count value.
- Per-digit decimal points, blanking, and a hex-to-segment decode.
- Sits between the counter datapath and the board display pins.

---
 rtl/display_pkg.sv | 30 +++
 rtl/display_scan_ctrl_if.sv | 24 ++
 rtl/display_scan_ctrl_hex_to_sevenseg.sv | 31 +++
 rtl/display_scan_ctrl.sv | 119 +++++++++++
 tb/tb_display_scan_ctrl.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the multiplexed seven-segment display scanner:
// active-low segment patterns, scan FSM states and a slot-counter width helper.
package display_pkg;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;
  localparam logic [6:0] SEG_A   = 7'h08;
  localparam logic [6:0] SEG_B   = 7'h03;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_D   = 7'h21;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_F   = 7'h0E;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  typedef enum logic {ST_DARK, ST_SCAN} scan_state_t;

  function automatic int slot_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Bundle between the counter datapath (master) and the display scanner (slave).
interface display_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    blank;
  logic [4*NUM_DIGITS-1:0] count;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   digit_select;
  logic [3:0]              cout;
  logic [6:0]              seg;
  logic                    dp;
  logic                    frame_start;

  modport master (
    output enable, blank, count, dp_in,
    input  digit_select, cout, seg, dp, frame_start
  );

  modport slave (
    input  enable, blank, count, dp_in,
    output digit_select, cout, seg, dp, frame_start
  );
endinterface

// File: rtl/display_scan_ctrl_hex_to_sevenseg.sv
// Combinational hex nibble to active-low seven-segment decoder (A, b, C, d, E, F).
module hex_to_sevenseg
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  always_comb begin
    // NOTE: assign a default before the case so no path leaves seg unassigned (no latch).
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/display_scan_ctrl.sv
// N-digit common-anode display scanner with frame-coherent count snapshot.
// Optional leading-zero suppression is built when LEADING_ZERO_BLANK_EN is defined.
module display_scan_ctrl #(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 100000,
  parameter int SEL_ACTIVE_LOW = 1
) (
  input logic               clk,
  input logic               reset,
  display_scan_ctrl_if.slave bus
);
  import display_pkg::*;

  localparam int SW = slot_width(NUM_DIGITS);
  localparam int PW = $clog2(CLK_DIV);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  scan_state_t             state, state_nx;
  logic [PW-1:0]           prescaler, prescaler_nx;
  logic [SW-1:0]           slot, slot_nx;
  logic [4*NUM_DIGITS-1:0] snap_count, snap_count_nx;
  logic [NUM_DIGITS-1:0]   snap_dp, snap_dp_nx;
  logic                    tick, load;
  logic [3:0]              nib;
  logic                    nib_dp;
  logic [NUM_DIGITS-1:0]   hot, sel_nx;
  logic                    suppress;
  logic [6:0]              seg_dec;

  // Prescaler, slot sequencing and snapshot capture.
  always_comb begin
    tick          = bus.enable && (prescaler == PW'(CLK_DIV - 1));
    prescaler_nx  = prescaler;
    state_nx      = state;
    slot_nx       = slot;
    load          = 1'b0;
    if (bus.enable) prescaler_nx = tick ? '0 : prescaler + 1'b1;
    if (tick) begin
      state_nx = ST_SCAN;
      case (state)
        ST_DARK: begin
          slot_nx = '0;
          load    = 1'b1;
        end
        default: begin
          load    = (slot == SW'(NUM_DIGITS - 1));
          slot_nx = load ? '0 : slot + 1'b1;
        end
      endcase
    end
    snap_count_nx = load ? bus.count : snap_count;
    snap_dp_nx    = load ? bus.dp_in : snap_dp;
  end

  // Slot mux: nibble, dp bit and strobe for the slot about to be shown.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    lead = 1'b1;
`endif
    nib      = '0;
    nib_dp   = 1'b0;
    hot      = '0;
    suppress = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      lead = lead && (snap_count_nx[4*(NUM_DIGITS-1-i) +: 4] == 4'h0)
                  && !snap_dp_nx[NUM_DIGITS-1-i];
`endif
      if (slot_nx == SW'(i)) begin
        nib                   = snap_count_nx[4*(NUM_DIGITS-1-i) +: 4];
        nib_dp                = snap_dp_nx[NUM_DIGITS-1-i];
        hot[NUM_DIGITS-1-i]   = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        suppress              = lead && (i != NUM_DIGITS - 1);
`endif
      end
    end
    if (state_nx == ST_DARK || bus.blank || suppress) sel_nx = SEL_OFF;
    else                                               sel_nx = (SEL_ACTIVE_LOW != 0) ? ~hot : hot;
  end

  hex_to_sevenseg u_dec (
    .nibble (nib),
    .seg    (seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= ST_DARK;
      prescaler        <= '0;
      slot             <= '0;
      snap_count       <= '0;
      snap_dp          <= '0;
      bus.digit_select <= SEL_OFF;
      bus.cout         <= '0;
      bus.seg          <= SEG_OFF;
      bus.dp           <= 1'b1;
      bus.frame_start  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      bus.frame_start <= tick && load;
      if (bus.enable) begin
        state            <= state_nx;
        prescaler        <= prescaler_nx;
        slot             <= slot_nx;
        snap_count       <= snap_count_nx;
        snap_dp          <= snap_dp_nx;
        bus.digit_select <= sel_nx;
        if (tick) begin
          bus.cout <= nib;
          bus.seg  <= seg_dec;
          bus.dp   <= ~nib_dp;
        end
      end
    end
  end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed phases plus random stimulus
// compared against a cycle-count based behavioural model.
module tb_display_scan_ctrl;
  localparam int N       = 4;
  localparam int CLK_DIV = 4;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  display_scan_ctrl_if #(.NUM_DIGITS(N)) bus ();

  display_scan_ctrl #(
    .NUM_DIGITS     (N),
    .CLK_DIV        (CLK_DIV),
    .SEL_ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: enabled cycles since reset determine ticks and the slot arithmetically.
  int           m_cnt;
  int           m_slot;
  bit           m_started;
  logic [15:0]  m_snap;
  logic [N-1:0] m_dps;
  logic [N-1:0] e_sel;
  logic [3:0]   e_cout;
  logic [6:0]   e_seg;
  logic         e_dp;
  logic         e_fs;

  task automatic model_reset();
    m_cnt = 0; m_slot = 0; m_started = 0; m_snap = '0; m_dps = '0;
    e_sel = '1; e_cout = '0; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
  endtask

  task automatic model_edge();
    bit           tick;
    bit           supp;
    logic [3:0]   nibble;
    logic [N-1:0] one;
    if (!bus.enable) begin
      e_fs = 1'b0;
      return;
    end
    m_cnt++;
    tick = (m_cnt % CLK_DIV) == 0;
    if (tick) begin
      m_started = 1;
      m_slot    = (m_cnt / CLK_DIV - 1) % N;
      if (m_slot == 0) begin
        m_snap = bus.count;
        m_dps  = bus.dp_in;
      end
      nibble = 4'(m_snap >> (4 * (N - 1 - m_slot)));
      e_cout = nibble;
      e_seg  = seg_tbl[nibble];
      e_dp   = ~m_dps[N-1-m_slot];
    end
    e_fs = tick && (m_slot == 0);
    supp = 0;
`ifdef LEADING_ZERO_BLANK_EN
    supp = (m_slot != N - 1) && ((m_snap >> (4 * (N - 1 - m_slot))) == 0)
                             && ((m_dps >> (N - 1 - m_slot)) == 0);
`endif
    one   = 1;
    e_sel = (!m_started || bus.blank || supp) ? '1 : ~(one << (N - 1 - m_slot));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/sel"},  32'(bus.digit_select), 32'(e_sel));
    check({tag, "/cout"}, 32'(bus.cout),         32'(e_cout));
    check({tag, "/seg"},  32'(bus.seg),          32'(e_seg));
    check({tag, "/dp"},   32'(bus.dp),           32'(e_dp));
    check({tag, "/fs"},   32'(bus.frame_start),  32'(e_fs));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    bus.enable = 1'b1;
    bus.blank  = 1'b0;
    bus.count  = 16'h1234;
    bus.dp_in  = '0;
    model_reset();
    #2 reset = 1'b1;
    #2;
    check_all("reset_async");
    @(posedge clk); #1;
    check_all("reset_hold");
    reset = 1'b0;

    // Dark for the first CLK_DIV-1 edges, then slot 0 on the tick edge.
    for (int i = 0; i < 3; i++) step("pre_tick");
    step("first_tick");
    check("first_sel", 32'(bus.digit_select), 32'h7);
    check("first_seg", 32'(bus.seg), 32'h79);
    check("first_fs",  32'(bus.frame_start), 32'h1);

    // Full scan, then a count change while slot 1 is shown.
    for (int i = 0; i < 5; i++) step("scan");
    bus.count = 16'hABCD;
    for (int i = 0; i < 30; i++) step("coherence");

    // Blank during a slot, then release.
    bus.blank = 1'b1;
    for (int i = 0; i < 6; i++) step("blank");
    check("blank_sel", 32'(bus.digit_select), 32'hF);
    bus.blank = 1'b0;
    for (int i = 0; i < 3; i++) step("unblank");

    // Freeze for 10 clocks, then resume.
    bus.enable = 1'b0;
    for (int i = 0; i < 10; i++) step("freeze");
    bus.enable = 1'b1;
    for (int i = 0; i < 10; i++) step("resume");

    // Decimal point for nibble 2 (slot 1).
    bus.dp_in = 4'b0100;
    for (int i = 0; i < 24; i++) step("dp");

    // Asynchronous reset between edges.
    #3 reset = 1'b1;
    model_reset();
    #1;
    check_all("reset_mid");
    check("reset_mid_seg", 32'(bus.seg), 32'h7F);
    #2 reset = 1'b0;
    for (int i = 0; i < 20; i++) step("post_reset");

    // Randomized controls and data.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)  bus.count = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.dp_in = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bus.blank = ~bus.blank;
      bus.enable = ($urandom_range(0, 9) != 0);
      step("random");
    end

`ifdef LEADING_ZERO_BLANK_EN
    bus.enable = 1'b1;
    bus.blank  = 1'b0;
    bus.dp_in  = '0;
    bus.count  = 16'h0007;
    for (int i = 0; i < 40; i++) step("lzb_7");
    bus.count  = 16'h0000;
    for (int i = 0; i < 40; i++) step("lzb_0");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
